data_mem_resp: RTL

- Data-memory responder at the far end of the datapath's load/store interface.
- Accepts word read/write requests on data_adr/data_out, waits a programmable latency, completes with a one-cycle mem_ready pulse, and returns read data on data_in.
- Lets the single-cycle core evolve toward stalling on slow memory; also serves as the bench memory model.

---
 rtl/data_mem_resp.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/data_mem_resp.sv
// data_mem_resp
//   Word-addressed data memory that answers the datapath's load/store port.
//   A request is accepted in IDLE. The access happens LATENCY edges after the
//   accept edge. After that a one-cycle mem_ready pulse signals completion.
//   Requests that arrive while busy are ignored, not queued.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   mem_read   load request
//   mem_write  store request
//   data_adr   byte address
//   data_out   store data
//   byte_en    store byte lanes; present only with DATA_MEM_BYTE_WRITE_EN
//   data_in    load data, registered and held between reads
//   mem_ready  completion pulse, high only in DONE
//   mem_err    error flag, meaningful only with mem_ready
//   busy       request in flight (WAIT or DONE)
//
// Build option
//   DATA_MEM_BYTE_WRITE_EN : adds byte_en[3:0] for per-byte stores.
//
// state | meaning
// IDLE  | waiting for a request; accepts on mem_read|mem_write
// WAIT  | latency countdown; the access happens when the counter is 0
// DONE  | mem_ready pulse; returns to IDLE on the next edge
module data_mem_resp #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] data_adr,
  input  logic [31:0] data_out,
`ifdef DATA_MEM_BYTE_WRITE_EN
  input  logic [3:0]  byte_en,
`endif
  output logic [31:0] data_in,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic          r_rd;
  logic          r_wr;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_complete;
  logic          w_misalign;
  logic          w_out_range;
  logic          w_conflict;
  logic [31:0]   w_wmask;

  assign w_accept    = (r_state == S_IDLE) && (mem_read || mem_write);
  assign w_complete  = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_misalign  = |data_adr[1:0];
  // Any address bit above the word index means the address is past the array.
  assign w_out_range = |data_adr[31:AW+2];
  assign w_conflict  = mem_read && mem_write;

`ifdef DATA_MEM_BYTE_WRITE_EN
  logic [3:0] r_be;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_be <= 4'd0;
    else if (w_accept) r_be <= byte_en;
  end

  assign w_wmask = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};
`else
  assign w_wmask = 32'hFFFF_FFFF;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_state_nxt = S_WAIT;
      S_WAIT:  if (w_complete) w_state_nxt = S_DONE;
      S_DONE:                  w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (r_state != S_IDLE);
    mem_ready = (r_state == S_DONE);
    mem_err   = (r_state == S_DONE) && r_err;
  end

  // Latency counter: loaded at accept, counts down to the completion edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   r_cnt <= 4'd0;
    else if (w_accept)                          r_cnt <= LAT_M1;
    else if (r_state == S_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
  end

  // Request capture: the requester holds its signals, but we latch them so the
  // access does not depend on what is on the bus at the completion edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= data_adr[AW+1:2];
      r_wdata <= data_out;
      r_rd    <= mem_read;
      r_wr    <= mem_write;
      r_err   <= w_misalign || w_out_range || w_conflict;
    end
  end

  // Load data. Only a clean read or an errored plain read changes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_in <= 32'd0;
    end else if (w_complete && r_rd && !r_wr) begin
      data_in <= r_err ? 32'd0 : r_mem[r_idx];
    end
  end

  // The array has no reset. A reset clears r_state, so w_complete stays low
  // and a write that is still in flight is dropped.
  always_ff @(posedge clk) begin
    if (w_complete && r_wr && !r_rd && !r_err) begin
      r_mem[r_idx] <= (r_mem[r_idx] & ~w_wmask) | (r_wdata & w_wmask);
    end
  end

endmodule
